// File: rtl/dct_quantizer.sv
// Quantizes the 8 coefficient rows of each 8x8 DCT block by multiplying with a per-position reciprocal table.
// Latency: 2 cycles from in_en to out_en; one row per cycle, rows may arrive with gaps or back-to-back.
// Backpressure: none; the stage always accepts in_en. Table writes are refused (tbl_wr_err) while a block is in flight.
// Ports: aclk/areset/locked (clock, sync reset, lock), in_row/in_en (row input), q_row/out_en/out_idx/block_done (row output),
//        busy (block in flight), tbl_we/tbl_addr/tbl_data (reciprocal table write), tbl_wr_err (refused write).
module dct_quantizer #(
    parameter int IN_WIDTH    = 36,
    parameter int OUT_WIDTH   = 16,
    parameter int RECIP_WIDTH = 17
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          locked,
    input  logic signed [IN_WIDTH-1:0]    in_row [0:7],
    input  logic                          in_en,
    output logic signed [OUT_WIDTH-1:0]   q_row [0:7],
    output logic                          out_en,
    output logic [2:0]                    out_idx,
    output logic                          block_done,
    output logic                          busy,
    input  logic                          tbl_we,
    input  logic [5:0]                    tbl_addr,
    input  logic [RECIP_WIDTH-1:0]        tbl_data,
    output logic                          tbl_wr_err
);

    // Exact product width: |in| fits IN_WIDTH unsigned bits, times the reciprocal.
    localparam int PW = IN_WIDTH + RECIP_WIDTH;

    // 2^16 is a step of 1 (identity).
    localparam logic [RECIP_WIDTH-1:0] RECIP_ONE = RECIP_WIDTH'(65536);
    // Symmetric saturation bound: the most-negative output code is never produced.
    localparam logic [OUT_WIDTH-1:0]   QMAX      = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    // Adding half an LSB before truncating the magnitude gives round-half-away-from-zero.
    localparam logic [PW-1:0]          HALF      = PW'(32768);

    // A lost clock lock behaves exactly like a reset.
    logic rst;
    assign rst = areset | ~locked;

    logic [RECIP_WIDTH-1:0] recip [0:63];
    logic [2:0]             in_cnt;
    logic [2:0]             in_cnt_nxt;

    logic                   s1_vld;
    logic [2:0]             s1_idx;
    logic [PW-1:0]          s1_p [0:7];
    logic [7:0]             s1_sign;

    logic [IN_WIDTH-1:0]    mag    [0:7];
    logic [PW-1:0]          prod   [0:7];
    logic [PW-1:0]          m_full [0:7];
    logic [OUT_WIDTH-1:0]   sat    [0:7];
    logic signed [OUT_WIDTH-1:0] q_next [0:7];
    logic                   wr_ok;

    assign in_cnt_nxt = in_en ? in_cnt + 3'd1 : in_cnt;
    // A write is taken only with no block in flight and no row arriving on the same edge.
    assign wr_ok      = tbl_we & ~busy & ~in_en;

    // Stage 1 datapath: sign-magnitude split, then exact magnitude * reciprocal.
    // The magnitude of the most-negative input still fits IN_WIDTH unsigned bits.
    always_comb begin
        for (int c = 0; c < 8; c++) begin
            mag[c]  = '0;
            prod[c] = '0;
        end
        for (int c = 0; c < 8; c++) begin
            mag[c]  = in_row[c][IN_WIDTH-1] ? IN_WIDTH'(-in_row[c]) : IN_WIDTH'(in_row[c]);
            prod[c] = PW'(mag[c]) * PW'(recip[{in_cnt, 3'(c)}]);
        end
    end

    // Stage 2 datapath: round, saturate the magnitude, then restore the sign.
    always_comb begin
        for (int c = 0; c < 8; c++) begin
            m_full[c] = '0;
            sat[c]    = '0;
            q_next[c] = '0;
        end
        for (int c = 0; c < 8; c++) begin
            m_full[c] = (s1_p[c] + HALF) >> 16;
            sat[c]    = (m_full[c] > PW'(QMAX)) ? QMAX : m_full[c][OUT_WIDTH-1:0];
            q_next[c] = s1_sign[c] ? -sat[c] : sat[c];
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            in_cnt     <= '0;
            s1_vld     <= 1'b0;
            s1_idx     <= '0;
            s1_sign    <= '0;
            out_en     <= 1'b0;
            out_idx    <= '0;
            block_done <= 1'b0;
            busy       <= 1'b0;
            tbl_wr_err <= 1'b0;
            for (int c = 0; c < 8; c++) begin
                s1_p[c]  <= '0;
                q_row[c] <= '0;
            end
            for (int i = 0; i < 64; i++) begin
                recip[i] <= RECIP_ONE;
            end
        end else begin
            in_cnt <= in_cnt_nxt;

            s1_vld <= in_en;
            if (in_en) begin
                s1_idx <= in_cnt;
                for (int c = 0; c < 8; c++) begin
                    s1_p[c]    <= prod[c];
                    s1_sign[c] <= in_row[c][IN_WIDTH-1];
                end
            end

            out_en     <= s1_vld;
            block_done <= s1_vld && (s1_idx == 3'd7);
            if (s1_vld) begin
                out_idx <= s1_idx;
                for (int c = 0; c < 8; c++) begin
                    q_row[c] <= q_next[c];
                end
            end

            // Built from next-state values so busy drops on the same edge that ends the row-7 out_en.
            busy <= in_en | (in_cnt_nxt != 3'd0) | s1_vld;

            tbl_wr_err <= tbl_we & ~wr_ok;
            if (wr_ok) begin
                recip[tbl_addr] <= tbl_data;
            end
        end
    end

endmodule

// File: tb/tb_dct_quantizer.sv
// Directed bench for dct_quantizer: table-driven uniform-block vectors plus hand sequences
// for table-write refusal, busy timing, gaps/back-to-back blocks and mid-block reset.
// Outputs are captured on the falling edge into a queue and compared against bench-computed values.
module tb_dct_quantizer;

    logic                aclk;
    logic                areset;
    logic                locked;
    logic signed [35:0]  in_row [0:7];
    logic                in_en;
    logic signed [15:0]  q_row [0:7];
    logic                out_en;
    logic [2:0]          out_idx;
    logic                block_done;
    logic                busy;
    logic                tbl_we;
    logic [5:0]          tbl_addr;
    logic [16:0]         tbl_data;
    logic                tbl_wr_err;

    dct_quantizer #(.IN_WIDTH(36), .OUT_WIDTH(16), .RECIP_WIDTH(17)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .locked     (locked),
        .in_row     (in_row),
        .in_en      (in_en),
        .q_row      (q_row),
        .out_en     (out_en),
        .out_idx    (out_idx),
        .block_done (block_done),
        .busy       (busy),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .tbl_wr_err (tbl_wr_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [127:0] q;
        logic [2:0]   idx;
        logic         done;
    } obs_t;

    typedef struct {
        logic signed [35:0] din;
        logic [16:0]        recip;
        logic signed [15:0] q;
    } vec_t;

    obs_t               obs_q [$];
    obs_t               mon_o;
    int                 done_cnt = 0;
    int                 total = 0;
    int                 bad = 0;
    logic signed [35:0] din  [64];
    logic signed [15:0] expq [64];

    // Output monitor, sampled on the falling edge.
    always @(negedge aclk) begin
        if (out_en) begin
            for (int l = 0; l < 8; l++) mon_o.q[l*16 +: 16] = q_row[l];
            mon_o.idx  = out_idx;
            mon_o.done = block_done;
            obs_q.push_back(mon_o);
        end
        if (block_done) done_cnt++;
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
        obs_q.delete();
    endtask

    task automatic wr(input logic [5:0] a, input logic [16:0] d);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_data = d;
        step();
        tbl_we   = 1'b0;
        chk($sformatf("wr_err_%0d", a), tbl_wr_err, 0);
    endtask

    task automatic load_all(input logic [16:0] d);
        for (int a = 0; a < 64; a++) wr(6'(a), d);
    endtask

    task automatic fill(input logic signed [35:0] v, input logic signed [15:0] e);
        for (int i = 0; i < 64; i++) begin
            din[i]  = v;
            expq[i] = e;
        end
    endtask

    // Drives nrows rows from din; optional gap after row gap_after; optional refused write
    // together with row we_row, or in the first gap cycle when we_gap is set.
    task automatic send_block(input int nrows, input int gap_after, input int gap_len,
                              input int we_row, input bit we_gap);
        for (int r = 0; r < nrows; r++) begin
            in_en = 1'b1;
            for (int c = 0; c < 8; c++) in_row[c] = din[r*8 + c];
            if (r == we_row) begin
                tbl_we = 1'b1; tbl_addr = 6'd0; tbl_data = 17'd4096;
            end
            step();
            tbl_we = 1'b0;
            if (r == we_row) chk("wr_err_with_in_en", tbl_wr_err, 1);
            if (r == gap_after) begin
                in_en = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    if (g == 0 && we_gap) begin
                        tbl_we = 1'b1; tbl_addr = 6'd0; tbl_data = 17'd4096;
                    end
                    step();
                    if (g == 0 && we_gap) begin
                        tbl_we = 1'b0;
                        chk("wr_err_in_gap", tbl_wr_err, 1);
                        chk("busy_in_gap", busy, 1);
                    end
                end
            end
        end
        in_en = 1'b0;
    endtask

    task automatic check_block(input string name);
        int   waited;
        obs_t o;
        waited = 0;
        while (obs_q.size() < 8 && waited < 60) begin
            step();
            waited++;
        end
        if (obs_q.size() < 8) begin
            chk({name, "_timeout_rows"}, obs_q.size(), 8);
            return;
        end
        for (int r = 0; r < 8; r++) begin
            o = obs_q.pop_front();
            chk($sformatf("%s_idx%0d", name, r), o.idx, r);
            chk($sformatf("%s_done%0d", name, r), o.done, (r == 7) ? 1 : 0);
            for (int l = 0; l < 8; l++)
                chk($sformatf("%s_r%0d_l%0d", name, r, l), $signed(o.q[l*16 +: 16]), expq[r*8 + l]);
        end
    endtask

    initial begin
        vec_t               vt [16];
        logic signed [35:0] lane_in  [8];
        logic signed [15:0] lane_exp [8];
        logic [16:0]        cur_recip;
        int                 d0;
        bit                 found;

        vt[0]  = '{36'sd100,          17'd65536,  16'sd100};
        vt[1]  = '{-36'sd100,         17'd65536, -16'sd100};
        vt[2]  = '{36'sd32767,        17'd65536,  16'sd32767};
        vt[3]  = '{-36'sd40000,       17'd65536, -16'sd32767};
        vt[4]  = '{-36'sd32768,       17'd65536, -16'sd32767};
        vt[5]  = '{36'sh800000000,    17'd65536, -16'sd32767};
        vt[6]  = '{36'sd24,           17'd4096,   16'sd2};
        vt[7]  = '{36'sd23,           17'd4096,   16'sd1};
        vt[8]  = '{-36'sd24,          17'd4096,  -16'sd2};
        vt[9]  = '{-36'sd8,           17'd4096,  -16'sd1};
        vt[10] = '{36'sd7,            17'd4096,   16'sd0};
        vt[11] = '{36'sd8,            17'd4096,   16'sd1};
        vt[12] = '{36'sd32768,        17'd1,      16'sd1};
        vt[13] = '{36'sd32767,        17'd1,      16'sd0};
        vt[14] = '{36'sh7FFFFFFFF,    17'd1,      16'sd32767};
        vt[15] = '{-36'sd1,           17'd131071, -16'sd2};

        areset = 1'b0; locked = 1'b1; in_en = 1'b0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        for (int c = 0; c < 8; c++) in_row[c] = '0;

        // Reset state
        do_reset();
        chk("rst_out_en", out_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_block_done", block_done, 0);
        chk("rst_tbl_wr_err", tbl_wr_err, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_q0", q_row[0], 0);

        // Identity table, mixed lanes, exact 2-cycle latency
        lane_in  = '{36'sd100, -36'sd100, 36'sd32767, -36'sd40000, 36'sd40000, -36'sd32768, 36'sd0, 36'sd1};
        lane_exp = '{16'sd100, -16'sd100, 16'sd32767, -16'sd32767, 16'sd32767, -16'sd32767, 16'sd0, 16'sd1};
        for (int r = 0; r < 8; r++)
            for (int l = 0; l < 8; l++) begin
                din[r*8 + l]  = lane_in[l];
                expq[r*8 + l] = lane_exp[l];
            end
        in_en = 1'b1;
        for (int c = 0; c < 8; c++) in_row[c] = din[c];
        step();
        chk("lat_after1_out_en", out_en, 0);
        in_en = 1'b0;
        step();
        chk("lat_after2_out_en", out_en, 1);
        chk("lat_after2_q3", q_row[3], -32767);
        obs_q.delete();
        do_reset();
        send_block(8, -1, 0, -1, 0);
        check_block("t1");

        // Table-driven uniform blocks
        cur_recip = 17'd65536;
        for (int i = 0; i < 16; i++) begin
            if (vt[i].recip != cur_recip) begin
                load_all(vt[i].recip);
                cur_recip = vt[i].recip;
            end
            fill(vt[i].din, vt[i].q);
            send_block(8, -1, 0, -1, 0);
            check_block($sformatf("vec%0d", i));
        end

        // Per-position step: entry 9 (row 1, col 1) = step 2
        do_reset();
        wr(6'd9, 17'd32768);
        fill(36'sd11, 16'sd11);
        expq[9] = 16'sd6;
        send_block(8, -1, 0, -1, 0);
        check_block("t3");

        // Refused writes, busy fall, accepted write
        do_reset();
        fill(36'sd100, 16'sd100);
        send_block(8, 3, 3, -1, 1);
        check_block("t4a");
        chk("t4_idle_busy", busy, 0);
        send_block(8, -1, 0, 0, 0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (out_en && out_idx == 3'd7) found = 1'b1;
            else step();
        end
        chk("t4_found_last_row", found, 1);
        chk("t4_busy_on_last", busy, 1);
        step();
        chk("t4_busy_fell", busy, 0);
        chk("t4_err_cleared", tbl_wr_err, 0);
        check_block("t4b");
        wr(6'd0, 17'd4096);
        expq[0] = 16'sd6;
        send_block(8, -1, 0, -1, 0);
        check_block("t4c");

        // Back-to-back blocks with a 3-cycle gap after row 3 of the first
        do_reset();
        fill(36'sd300, 16'sd300);
        d0 = done_cnt;
        send_block(8, 3, 3, -1, 0);
        send_block(8, -1, 0, -1, 0);
        check_block("t5a");
        check_block("t5b");
        repeat (5) step();
        chk("t5_extra_rows", obs_q.size(), 0);
        chk("t5_done_pulses", done_cnt - d0, 2);

        // Reset mid-block: table back to identity, no stray outputs, fresh block from row 0
        do_reset();
        wr(6'd5, 17'd4096);
        fill(36'sd50, 16'sd50);
        send_block(5, -1, 0, -1, 0);
        areset = 1'b1;
        step();
        areset = 1'b0;
        obs_q.delete();
        chk("t6_out_en_after_rst", out_en, 0);
        chk("t6_busy_after_rst", busy, 0);
        repeat (6) step();
        chk("t6_stray_rows", obs_q.size(), 0);
        send_block(8, -1, 0, -1, 0);
        check_block("t6");

        // Loss of lock mid-block acts as reset
        send_block(3, -1, 0, -1, 0);
        locked = 1'b0;
        step();
        locked = 1'b1;
        obs_q.delete();
        chk("lock_busy", busy, 0);
        repeat (5) step();
        chk("lock_stray_rows", obs_q.size(), 0);
        send_block(8, -1, 0, -1, 0);
        check_block("lock");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
